// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants and the parity
// function used by both uart_tx and uart_rx_parity so the two always agree.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Parity bit a transmitter appends; zero-extension does not change the XOR.
  function automatic logic parity_of(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: start, DBIT data bits LSB first, one parity bit, stop.
// Samples mid-bit using the shared 16x s_tick; reports parity/framing errors.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  uart_state_e     state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            p, p_n;
  logic            armed, armed_n;
  logic            rx_s;
  logic            fin;
  logic [DBIT-1:0] dout_n;
  logic            perr_n, ferr_n;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      p            <= 1'b0;
      armed        <= 1'b1;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      p            <= p_n;
      armed        <= armed_n;
      dout         <= dout_n;
      parity_err   <= perr_n;
      frame_err    <= ferr_n;
      rx_done_tick <= fin;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    p_n     = p;
    fin     = 1'b0;
    case (state)
      IDLE:
        if (!rx_s && armed) begin
          state_n = START;
          s_n     = '0;
        end
      START:
        if (s_tick) begin
          if (s == S_MID) begin
            s_n     = '0;
            n_n     = '0;
            state_n = rx_s ? IDLE : DATA;
          end else s_n = s + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (s == S_BIT) begin
            b_n = DBIT'({rx_s, b} >> 1);
            s_n = '0;
            if (n == N_LAST) state_n = PARITY;
            else             n_n     = n + 1'b1;
          end else s_n = s + 1'b1;
        end
      PARITY:
        if (s_tick) begin
          if (s == S_BIT) begin
            p_n     = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else s_n = s + 1'b1;
        end
      STOP:
        if (s_tick) begin
          if (s == S_STOP) begin
            s_n     = '0;
            fin     = 1'b1;
            state_n = IDLE;
          end else s_n = s + 1'b1;
        end
      default: state_n = IDLE;
    endcase
    // A low stop bit leaves the line disarmed so a held break yields one frame.
    armed_n = fin ? rx_s : (armed | rx_s);
  end

  always_comb begin
    dout_n = dout;
    perr_n = parity_err;
    ferr_n = frame_err;
    if (fin) begin
      dout_n = b;
      perr_n = parity_of(32'(b), 1'(PARITY_ODD)) != p;
      ferr_n = ~rx_s;
    end
  end

endmodule
